ro_puf_sequencer: RTL
=====================

Name: ro_puf_sequencer

Overview:
- Measurement controller for the ring-oscillator counter group. It sequences NUM_BITS challenge pairs through the counter datapath.
- For each bit it: drives the two 4-bit RO-select challenges, holds the counters in reset, opens a fixed-length counting window, then samples the comparator response bit.
- Results are assembled into a response word with a per-bit tie mask and reported over a start/busy/done handshake.
- Sits between the system/host logic and the counter group.

Parameters:
- NUM_BITS, 8, response bits generated per request (1..32)
- CHA_W, 4, challenge index width (selects 1 of 2**CHA_W ROs)
- CNT_W, 4, width of counter group count outputs
- SETTLE_CYCLES, 4, cycles counters are held in reset before each window (>=1)
- WINDOW_CYCLES, 256, cycles RO counting is enabled per bit (>=1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request pulse; sampled only in IDLE
- base0  in  CHA_W  first challenge of bit 0
- base1  in  CHA_W  second challenge of bit 0
- resp_in  in  1  comparator response from counter group
- cnt_a  in  CNT_W  count of RO selected by cha0
- cnt_b  in  CNT_W  count of RO selected by cha1
- cha0  out  CHA_W  RO select A to counter group
- cha1  out  CHA_W  RO select B to counter group
- cnt_reset  out  1  active-low counter clear to counter group
- ro_en  out  1  RO/counting enable
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse, response valid
- err  out  1  one-cycle pulse, request rejected
- response  out  NUM_BITS  assembled response word, bit i = pair i
- tie_mask  out  NUM_BITS  bit i set when cnt_a==cnt_b at sample i

Behaviour:
- Reset (async, reset==0) values:
  - State IDLE.
  - cha0 = cha1 = 0, cnt_reset = 0 (counters held clear), ro_en = 0.
  - busy = done = err = 0; response = tie_mask = 0; bit_idx = 0.
  - Reset mid-sequence aborts immediately; partial results are discarded.
- FSM states: IDLE, CLEAR, MEASURE, SAMPLE, DONE.
- IDLE:
  - cnt_reset = 0, ro_en = 0.
  - start=1 with base0 != base1: latch bases, clear response/tie_mask, bit_idx = 0, go to CLEAR; busy = 1 from the next cycle.
  - start=1 with base0 == base1: err = 1 for one cycle, stay in IDLE, response/tie_mask unchanged.
- CLEAR: SETTLE_CYCLES cycles.
  - cha0 = base0 + bit_idx, cha1 = base1 + bit_idx, both modulo 2**CHA_W (wrap 15 -> 0 at CHA_W=4).
  - cnt_reset = 0, ro_en = 0.
  - cha0/cha1 stay stable through CLEAR, MEASURE and SAMPLE of the same bit.
  - The offset is identical on both selects, so cha0 != cha1 always holds.
- MEASURE: WINDOW_CYCLES cycles, cnt_reset = 1, ro_en = 1.
- SAMPLE: 1 cycle.
  - ro_en = 0, cnt_reset = 1 (counts frozen).
  - response[bit_idx] <= resp_in; tie_mask[bit_idx] <= (cnt_a == cnt_b).
  - If bit_idx == NUM_BITS-1, go to DONE; else bit_idx++ and go to CLEAR.
- DONE: 1 cycle.
  - done = 1, busy = 0 from the following cycle.
  - cnt_reset returns to 0 in IDLE.
- Latency: start-to-done = 1 + NUM_BITS*(SETTLE_CYCLES+WINDOW_CYCLES+1) cycles.
- start while busy (any non-IDLE state) is ignored; no queueing.
- response/tie_mask hold their value after done until the next accepted start.
- Internal counters: window counter sized clog2(max(SETTLE_CYCLES,WINDOW_CYCLES)+1); no overflow is permitted.

Decomposition:
- Package ro_puf_pkg holds:
  - state enum (IDLE, CLEAR, MEASURE, SAMPLE, DONE)
  - default CHA_W/CNT_W constants
  - the cycles-per-bit latency function
- One natural sub-module, ro_puf_window_timer: a loadable down-counter with terminal-count flag, reused for both the CLEAR and MEASURE phases.

Test Plan (NUM_BITS=4, SETTLE_CYCLES=2, WINDOW_CYCLES=8; 11 cycles/bit):
- Normal run:
  - Stimulus: base0=12, base1=8, start pulse; resp_in driven 1,0,1,1 per SAMPLE.
  - Required: done exactly 45 cycles after start; response=4'b1101.
  - Required: cha0 sequence 12,13,14,15; cha1 sequence 8,9,10,11.
  - Required: ro_en high 8 cycles per bit; cnt_reset low 2 cycles before each window.
- Wrap-around:
  - Stimulus: base0=14, base1=3.
  - Required: cha0 = 14,15,0,1; cha1 = 3,4,5,6; no stall.
- Equal bases:
  - Stimulus: base0=base1=5, start.
  - Required: err pulses 1 cycle; busy stays 0; response keeps its previous value.
- Ties:
  - Stimulus: cnt_a=cnt_b=7 at SAMPLE of bit 2, unequal at the others.
  - Required: tie_mask=4'b0100.
- Start while busy:
  - Stimulus: second start 20 cycles into a run.
  - Required: ignored; single done at cycle 45; results from the first request only.
- Reset mid-MEASURE:
  - Stimulus: reset asserted asynchronously during MEASURE of bit 1.
  - Required: immediately ro_en=0, cnt_reset=0, busy=0, response=0; after release a new start runs cleanly.

Source files
------------

// File: rtl/ro_puf_pkg.sv
// Shared types and constants for the ring-oscillator PUF measurement sequencer.
package ro_puf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_MEASURE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam int CHA_W_DEF = 4;
  localparam int CNT_W_DEF = 4;

  function automatic int cycles_per_bit(input int settle, input int window);
    return settle + window + 1;
  endfunction

  // Single DONE cycle plus every bit's clear/measure/sample slot
  function automatic int start_to_done(input int nbits, input int settle, input int window);
    return 1 + nbits * cycles_per_bit(settle, window);
  endfunction

endpackage

// File: rtl/ro_puf_window_timer.sv
// Loadable down-counter; tc_o is high while the count sits at zero.
module ro_puf_window_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/ro_puf_sequencer.sv
// Steps NUM_BITS challenge pairs through the RO counter group and assembles
// the response word plus a per-bit tie mask.
//
// state   | meaning
// IDLE    | waiting for start; counters held clear
// CLEAR   | challenges driven, counters held in reset for SETTLE_CYCLES
// MEASURE | counters enabled for WINDOW_CYCLES
// SAMPLE  | counts frozen, response and tie bit captured
// DONE    | done pulse, returns to IDLE
module ro_puf_sequencer
  import ro_puf_pkg::*;
#(
  parameter int NUM_BITS      = 8,
  parameter int CHA_W         = CHA_W_DEF,
  parameter int CNT_W         = CNT_W_DEF,
  parameter int SETTLE_CYCLES = 4,
  parameter int WINDOW_CYCLES = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CHA_W-1:0]    base0,
  input  logic [CHA_W-1:0]    base1,
  input  logic                resp_in,
  input  logic [CNT_W-1:0]    cnt_a,
  input  logic [CNT_W-1:0]    cnt_b,
  output logic [CHA_W-1:0]    cha0,
  output logic [CHA_W-1:0]    cha1,
  output logic                cnt_reset,
  output logic                ro_en,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [NUM_BITS-1:0] response,
  output logic [NUM_BITS-1:0] tie_mask
);

  localparam int MAX_CYC = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
  localparam int TMR_W   = $clog2(MAX_CYC + 1);
  localparam int BIDX_W  = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam logic [TMR_W-1:0]  SETTLE_VAL = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0]  WINDOW_VAL = TMR_W'(WINDOW_CYCLES - 1);
  localparam logic [BIDX_W-1:0] LAST_IDX   = BIDX_W'(NUM_BITS - 1);

  state_t              state_q;
  logic [CHA_W-1:0]    base0_q, base1_q, cha0_q, cha1_q;
  logic [BIDX_W-1:0]   bit_idx_q;
  logic [NUM_BITS-1:0] response_q, tie_q;
  logic                cnt_reset_q, ro_en_q, busy_q, done_q, err_q;

  logic                tmr_load, tmr_tc, last_bit, accept;
  logic [TMR_W-1:0]    tmr_val;

  assign accept   = start && (base0 != base1);
  assign last_bit = (bit_idx_q == LAST_IDX);

  // The timer is reloaded on every phase entry so its tc marks the last cycle of the phase
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = SETTLE_VAL;
    case (state_q)
      ST_IDLE:   tmr_load = accept;
      ST_CLEAR:  begin
        tmr_load = tmr_tc;
        tmr_val  = WINDOW_VAL;
      end
      ST_SAMPLE: tmr_load = !last_bit;
      default:   tmr_load = 1'b0;
    endcase
  end

  ro_puf_window_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .rst_n      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tc_o       (tmr_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      base0_q     <= '0;
      base1_q     <= '0;
      cha0_q      <= '0;
      cha1_q      <= '0;
      bit_idx_q   <= '0;
      response_q  <= '0;
      tie_q       <= '0;
      cnt_reset_q <= 1'b0;
      ro_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            base0_q    <= base0;
            base1_q    <= base1;
            cha0_q     <= base0;
            cha1_q     <= base1;
            bit_idx_q  <= '0;
            response_q <= '0;
            tie_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= ST_CLEAR;
          end else if (start) begin
            err_q <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (tmr_tc) begin
            cnt_reset_q <= 1'b1;
            ro_en_q     <= 1'b1;
            state_q     <= ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (tmr_tc) begin
            ro_en_q <= 1'b0;
            state_q <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          response_q[bit_idx_q] <= resp_in;
          tie_q[bit_idx_q]      <= (cnt_a == cnt_b);
          if (last_bit) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            bit_idx_q   <= bit_idx_q + 1'b1;
            cha0_q      <= base0_q + CHA_W'(bit_idx_q + 1'b1);
            cha1_q      <= base1_q + CHA_W'(bit_idx_q + 1'b1);
            cnt_reset_q <= 1'b0;
            state_q     <= ST_CLEAR;
          end
        end
        ST_DONE: begin
          busy_q      <= 1'b0;
          cnt_reset_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cha0      = cha0_q;
  assign cha1      = cha1_q;
  assign cnt_reset = cnt_reset_q;
  assign ro_en     = ro_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign response  = response_q;
  assign tie_mask  = tie_q;

endmodule
